// File: rtl/avalon_arbiter_2h.sv
// avalon_arbiter_2h
//   Shares one Avalon-MM agent (block RAM controller) between two Avalon hosts.
//   A grant covers a whole single or burst transaction, so beats from different
//   hosts never interleave. Arbitration costs one IDLE cycle before the first
//   downstream command.
//
// Optional build macro: ARB_FIXED_PRIORITY_EN
//   defined   : simultaneous requests always go to host 0 (host 1 may starve)
//   undefined : round-robin, simultaneous requests go to the host != last grant
//
// Ports
//   clk, reset              shared clock, synchronous active-high reset
//   a0_* / a1_*             agent side for host 0 / host 1:
//                           address, read, write, writedata, byteenable,
//                           burstcount in; readdata, readdatavalid, waitrequest out
//   h_*                     host side toward the RAM agent: address, read, write,
//                           writedata, byteenable, burstcount out;
//                           readdata, readdatavalid, waitrequest in
module avalon_arbiter_2h #(
  parameter int BURSTCOUNT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             a0_address_i,
  input  logic                    a0_read_i,
  input  logic                    a0_write_i,
  input  logic [31:0]             a0_writedata_i,
  input  logic [3:0]              a0_byteenable_i,
  input  logic [BURSTCOUNT_W-1:0] a0_burstcount_i,
  output logic [31:0]             a0_readdata_o,
  output logic                    a0_readdatavalid_o,
  output logic                    a0_waitrequest_o,
  input  logic [31:0]             a1_address_i,
  input  logic                    a1_read_i,
  input  logic                    a1_write_i,
  input  logic [31:0]             a1_writedata_i,
  input  logic [3:0]              a1_byteenable_i,
  input  logic [BURSTCOUNT_W-1:0] a1_burstcount_i,
  output logic [31:0]             a1_readdata_o,
  output logic                    a1_readdatavalid_o,
  output logic                    a1_waitrequest_o,
  output logic [31:0]             h_address_o,
  output logic                    h_read_o,
  output logic                    h_write_o,
  output logic [31:0]             h_writedata_o,
  output logic [3:0]              h_byteenable_o,
  output logic [BURSTCOUNT_W-1:0] h_burstcount_o,
  input  logic [31:0]             h_readdata_i,
  input  logic                    h_readdatavalid_i,
  input  logic                    h_waitrequest_i
);

  typedef struct packed {
    logic [31:0]             addr;
    logic                    read;
    logic                    write;
    logic [31:0]             wdata;
    logic [3:0]              be;
    logic [BURSTCOUNT_W-1:0] bc;
  } req_t;

  typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

  localparam logic [BURSTCOUNT_W-1:0] ONE = BURSTCOUNT_W'(1);

  req_t [1:0]              req;
  req_t                    sel;
  logic [1:0]              req_v;
  logic [1:0]              wait_v;
  logic [1:0]              rdv_v;

  // owner_q is only meaningful outside IDLE; IDLE itself means "no owner"
  state_t                  state_q;
  logic                    owner_q;
  logic                    rd_acc_q;   // read command of this grant already accepted
  logic [BURSTCOUNT_W-1:0] beat_cnt_q;
  logic [BURSTCOUNT_W-1:0] bc_q;
`ifndef ARB_FIXED_PRIORITY_EN
  logic                    last_grant_q;
`endif

  logic                    pick;
  logic                    cand_rd;
  logic [BURSTCOUNT_W-1:0] sel_bc;
  logic [BURSTCOUNT_W-1:0] beat_inc;
  logic                    rd_accept;
  logic                    wr_accept;
  logic                    rdv_fwd;
  logic                    wr_last;

  assign req[0] = {a0_address_i, a0_read_i, a0_write_i, a0_writedata_i,
                   a0_byteenable_i, a0_burstcount_i};
  assign req[1] = {a1_address_i, a1_read_i, a1_write_i, a1_writedata_i,
                   a1_byteenable_i, a1_burstcount_i};

  assign req_v[0] = a0_read_i | a0_write_i;
  assign req_v[1] = a1_read_i | a1_write_i;

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick = ~req_v[0];
`else
  assign pick = (&req_v) ? ~last_grant_q : req_v[1];
`endif

  // read wins over write when a host drives both; the write waits for a later grant
  assign cand_rd  = pick ? req[1].read : req[0].read;

  assign sel      = req[owner_q];
  assign sel_bc   = (sel.bc == '0) ? ONE : sel.bc;
  assign beat_inc = beat_cnt_q + ONE;

  // downstream command: owner's fields straight through, strobes gated by state
  assign h_address_o    = sel.addr;
  assign h_writedata_o  = sel.wdata;
  assign h_byteenable_o = sel.be;
  assign h_burstcount_o = sel.bc;
  assign h_read_o       = ~reset & (state_q == GRANT_RD) & sel.read & ~rd_acc_q;
  assign h_write_o      = ~reset & (state_q == GRANT_WR) & sel.write;

  assign rd_accept = h_read_o & ~h_waitrequest_i;
  assign wr_accept = h_write_o & ~h_waitrequest_i;
  // readdatavalid outside an accepted read (IDLE, stale beats after reset) is dropped
  assign rdv_fwd   = ~reset & (state_q == GRANT_RD) & rd_acc_q & h_readdatavalid_i;
  // bc_q is not loaded yet on the first beat, so use the live burstcount there
  assign wr_last   = (beat_cnt_q == '0) ? (sel_bc == ONE) : (beat_inc == bc_q);

  // once the read is accepted the owner is held off: a second read cannot be
  // issued inside the same grant
  for (genvar i = 0; i < 2; i++) begin : g_host
    assign wait_v[i] = reset | (state_q == IDLE) | (owner_q != 1'(i)) |
                       ((state_q == GRANT_RD) & rd_acc_q) | h_waitrequest_i;
    assign rdv_v[i]  = rdv_fwd & (owner_q == 1'(i));
  end

  assign a0_waitrequest_o   = wait_v[0];
  assign a1_waitrequest_o   = wait_v[1];
  assign a0_readdatavalid_o = rdv_v[0];
  assign a1_readdatavalid_o = rdv_v[1];
  assign a0_readdata_o      = h_readdata_i;
  assign a1_readdata_o      = h_readdata_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rd_acc_q     <= 1'b0;
      beat_cnt_q   <= '0;
      bc_q         <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          rd_acc_q   <= 1'b0;
          if (|req_v) begin
            owner_q      <= pick;
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant_q <= pick;
`endif
            state_q      <= cand_rd ? GRANT_RD : GRANT_WR;
          end
        end
        GRANT_RD: begin
          if (rd_accept) begin
            bc_q     <= sel_bc;
            rd_acc_q <= 1'b1;
          end
          if (rdv_fwd) begin
            beat_cnt_q <= beat_inc;
            if (beat_inc == bc_q) state_q <= IDLE;
          end
        end
        GRANT_WR: begin
          // a released write just idles here until the remaining beats arrive
          if (wr_accept) begin
            beat_cnt_q <= beat_inc;
            if (beat_cnt_q == '0) bc_q <= sel_bc;
            if (wr_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_arbiter_2h.sv
`timescale 1ns/1ps
module tb_avalon_arbiter_2h;
  localparam int BCW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // host-side drive
  logic [31:0]    a_addr [2];
  logic [31:0]    a_wdata[2];
  logic [3:0]     a_be   [2];
  logic [BCW-1:0] a_bc   [2];
  logic [1:0]     a_rd = '0, a_wr = '0;
  // DUT agent outputs
  logic [31:0] a0_rdata_w, a1_rdata_w;
  logic        a0_rdv_w, a1_rdv_w, a0_wait_w, a1_wait_w;
  logic [31:0] a_rdata[2];
  logic [1:0]  a_rdv, a_wait;
  assign a_rdata[0] = a0_rdata_w;
  assign a_rdata[1] = a1_rdata_w;
  assign a_rdv  = {a1_rdv_w, a0_rdv_w};
  assign a_wait = {a1_wait_w, a0_wait_w};
  // downstream
  logic [31:0]    h_addr, h_wdata;
  logic [31:0]    h_rdata = '0;
  logic           h_rd, h_wr;
  logic           h_rdv = 1'b0, h_wait = 1'b0;
  logic [3:0]     h_be;
  logic [BCW-1:0] h_bc;

  avalon_arbiter_2h #(.BURSTCOUNT_W(BCW)) dut (
    .clk(clk), .reset(reset),
    .a0_address_i(a_addr[0]), .a0_read_i(a_rd[0]), .a0_write_i(a_wr[0]),
    .a0_writedata_i(a_wdata[0]), .a0_byteenable_i(a_be[0]), .a0_burstcount_i(a_bc[0]),
    .a0_readdata_o(a0_rdata_w), .a0_readdatavalid_o(a0_rdv_w), .a0_waitrequest_o(a0_wait_w),
    .a1_address_i(a_addr[1]), .a1_read_i(a_rd[1]), .a1_write_i(a_wr[1]),
    .a1_writedata_i(a_wdata[1]), .a1_byteenable_i(a_be[1]), .a1_burstcount_i(a_bc[1]),
    .a1_readdata_o(a1_rdata_w), .a1_readdatavalid_o(a1_rdv_w), .a1_waitrequest_o(a1_wait_w),
    .h_address_o(h_addr), .h_read_o(h_rd), .h_write_o(h_wr), .h_writedata_o(h_wdata),
    .h_byteenable_o(h_be), .h_burstcount_o(h_bc),
    .h_readdata_i(h_rdata), .h_readdatavalid_i(h_rdv), .h_waitrequest_i(h_wait));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bce(input logic [BCW-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural RAM agent + shadow memory ----------------
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  int          rd_q[$];
  int          cmd_log[$];   // address of every new downstream command, in order
  int          wr_base = 0, wr_idx = 0, wr_left = 0;
  bit          gaps = 1'b0;

  always @(posedge clk) begin
    int w;
    if (rd_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
      w = rd_q.pop_front();
      h_rdv   <= 1'b1;
      h_rdata <= mem[w];
    end else begin
      h_rdv   <= 1'b0;
      h_rdata <= 32'h0BAD0BAD;
    end
    if (reset) wr_left <= 0;
    else begin
      if (h_rd && !h_wait) begin
        chk("no_overlap_rd", {31'd0, (rd_q.size() == 0 && wr_left == 0)}, 32'd1);
        cmd_log.push_back(int'(h_addr));
        for (int i = 0; i < bce(h_bc); i++) rd_q.push_back((int'(h_addr[9:2]) + i) & 255);
      end
      if (h_wr && !h_wait) begin
        if (wr_left == 0) begin
          chk("no_overlap_wr", {31'd0, (rd_q.size() == 0)}, 32'd1);
          cmd_log.push_back(int'(h_addr));
          w = int'(h_addr[9:2]);
          wr_base <= w;
          wr_idx  <= 1;
          wr_left <= bce(h_bc) - 1;
        end else begin
          w = (wr_base + wr_idx) & 255;
          wr_idx  <= wr_idx + 1;
          wr_left <= wr_left - 1;
        end
        mem[w] <= merge(mem[w], h_wdata, h_be);
      end
    end
    h_wait <= gaps ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // readdatavalid may only reach a host with a read in flight
  bit exp_rd[2] = '{1'b0, 1'b0};
  always @(negedge clk)
    for (int n = 0; n < 2; n++)
      if (a_rdv[n]) chk($sformatf("rdv_only_owner%0d", n), {31'd0, exp_rd[n]}, 32'd1);

  // ---------------- host tasks ----------------
  int wbeats[2] = '{0, 0};

  task automatic wait_accept(input int n, output bit ok);
    bit w;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); w = a_wait[n];
      @(posedge clk); #1;
      if (!w) begin ok = 1'b1; break; end
    end
  endtask

  task automatic host_read(input int n, input logic [31:0] addr, input logic [BCW-1:0] bc,
                           output logic [31:0] first);
    bit ok;
    int nb = bce(bc), got = 0;
    first = '0;
    a_addr[n] = addr; a_bc[n] = bc; a_rd[n] = 1'b1; exp_rd[n] = 1'b1;
    wait_accept(n, ok);
    a_rd[n] = 1'b0;
    if (!ok) begin chk("rd_accept_timeout", 0, 1); exp_rd[n] = 1'b0; return; end
    for (int t = 0; t < 400 && got < nb; t++) begin
      @(negedge clk);
      if (a_rdv[n]) begin
        chk($sformatf("rd_data_h%0d", n), a_rdata[n], exp_mem[(int'(addr[9:2]) + got) & 255]);
        if (got == 0) first = a_rdata[n];
        got++;
      end
    end
    chk("rd_beats", 32'(got), 32'(nb));
    @(posedge clk); #1;
    exp_rd[n] = 1'b0;
  endtask

  task automatic host_write(input int n, input logic [31:0] addr, input logic [BCW-1:0] bc,
                            input bit hgaps);
    bit ok;
    int nb = bce(bc), w;
    logic [31:0] d;
    logic [3:0] be;
    a_addr[n] = addr; a_bc[n] = bc; wbeats[n] = 0;
    for (int i = 0; i < nb; i++) begin
      if (hgaps && i > 0 && $urandom_range(0, 2) == 0) begin
        a_wr[n] = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      d = $urandom; be = 4'($urandom_range(1, 15));
      a_wdata[n] = d; a_be[n] = be; a_wr[n] = 1'b1;
      wait_accept(n, ok);
      if (!ok) begin chk("wr_accept_timeout", 0, 1); a_wr[n] = 1'b0; return; end
      w = (int'(addr[9:2]) + i) & 255;
      exp_mem[w] = merge(exp_mem[w], d, be);
      wbeats[n] = i + 1;
    end
    a_wr[n] = 1'b0;
  endtask

  task automatic rand_host(input int n, input int cnt);
    logic [31:0] tmp;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      tmp = 32'((128 * n + $urandom_range(0, 119)) * 4);
      if ($urandom_range(0, 1) == 1) host_write(n, tmp, 4'($urandom_range(0, 8)), 1'b1);
      else                           host_read(n, tmp, 4'($urandom_range(0, 8)), tmp);
    end
  endtask

  // ---------------- arbitration vectors ----------------
  typedef struct {
    int op0;        // 0 none, 1 read, 2 write
    int op1;
    int exp_first;  // host whose command reaches h first
  } vec_t;
  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] ad0, ad1, tmp0, tmp1;
  bit ok;
  int got, ncmd;

  initial begin
`ifdef ARB_FIXED_PRIORITY_EN
    tbl = '{'{1,1,0}, '{2,2,0}, '{0,1,1}, '{2,2,0}, '{2,0,0},
            '{1,1,0}, '{1,1,0}, '{0,2,1}, '{2,2,0}};
`else
    tbl = '{'{1,1,0}, '{2,2,0}, '{0,1,1}, '{2,2,0}, '{2,0,0},
            '{1,1,1}, '{1,1,1}, '{0,2,1}, '{2,2,0}};
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
      exp_mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    end
    for (int n = 0; n < 2; n++) begin
      a_addr[n] = '0; a_wdata[n] = '0; a_be[n] = 4'hF; a_bc[n] = 4'd1;
    end

    // reset held 3 cycles with both hosts requesting
    a_rd = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("rst_wait", {30'd0, a_wait}, 32'd3);
      chk("rst_rdv", {30'd0, a_rdv}, 32'd0);
      chk("rst_hcmd", {30'd0, h_rd, h_wr}, 32'd0);
    end
    @(posedge clk); #1;
    a_rd = 2'b00; reset = 1'b0;
    @(posedge clk); #1;

    // arbitration table, starting from the reset value of the grant history
    for (int i = 0; i < 9; i++) begin
      ad0 = 32'(8 * i); ad1 = 32'(8 * i + 4);
      cmd_log.delete();
      fork
        begin
          if (tbl[i].op0 == 1) host_read(0, ad0, 4'd1, tmp0);
          else if (tbl[i].op0 == 2) host_write(0, ad0, 4'd1, 1'b0);
        end
        begin
          if (tbl[i].op1 == 1) host_read(1, ad1, 4'd1, tmp1);
          else if (tbl[i].op1 == 2) host_write(1, ad1, 4'd1, 1'b0);
        end
      join
      ncmd = (tbl[i].op0 != 0 ? 1 : 0) + (tbl[i].op1 != 0 ? 1 : 0);
      chk($sformatf("arb_ncmd_%0d", i), 32'(cmd_log.size()), 32'(ncmd));
      if (cmd_log.size() > 0)
        chk($sformatf("arb_first_%0d", i), 32'(cmd_log[0]), tbl[i].exp_first != 0 ? ad1 : ad0);
    end

    // single write: one arbitration cycle, then the write is on h
    @(posedge clk); #1;
    a_addr[0] = 32'h10; a_wdata[0] = 32'hDEADBEEF; a_be[0] = 4'hF; a_bc[0] = 4'd1; a_wr[0] = 1'b1;
    @(negedge clk);
    chk("wr_arb_cycle_hwrite", {31'd0, h_wr}, 32'd0);
    chk("wr_arb_cycle_wait", {31'd0, a_wait[0]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_fwd_hwrite", {31'd0, h_wr}, 32'd1);
    chk("wr_fwd_addr", h_addr, 32'h10);
    chk("wr_fwd_data", h_wdata, 32'hDEADBEEF);
    chk("wr_fwd_wait_owner", {30'd0, a_wait}, 32'd2);
    @(posedge clk); #1;
    a_wr[0] = 1'b0; exp_mem[4] = 32'hDEADBEEF;
    host_read(0, 32'h10, 4'd1, tmp0);
    chk("rd_deadbeef", tmp0, 32'hDEADBEEF);

    // read+write from one host: read goes first, write follows
    a_addr[0] = 32'h70; a_bc[0] = 4'd0; a_wdata[0] = 32'h12345678; a_be[0] = 4'hF;
    a_rd[0] = 1'b1; a_wr[0] = 1'b1; exp_rd[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_read_first", {31'd0, h_rd}, 32'd1);
    chk("rw_no_write", {31'd0, h_wr}, 32'd0);
    @(posedge clk); #1;
    a_rd[0] = 1'b0;
    got = 0;
    for (int t = 0; t < 20 && got < 1; t++) begin
      @(negedge clk);
      if (a_rdv[0]) begin chk("rw_rdata", a_rdata[0], exp_mem[28]); got++; end
    end
    chk("rw_rbeats", 32'(got), 32'd1);
    @(posedge clk); #1;
    exp_rd[0] = 1'b0;
    wait_accept(0, ok);
    a_wr[0] = 1'b0;
    chk("rw_write_later", {31'd0, ok}, 32'd1);
    exp_mem[28] = 32'h12345678;
    host_read(0, 32'h70, 4'd1, tmp0);
    chk("rw_readback", tmp0, 32'h12345678);

    // a1 read burst of 4; a0 write requested mid-burst waits for all 4 beats
    cmd_log.delete();
    fork
      host_read(1, 32'h20, 4'd4, tmp1);
      begin repeat (3) @(posedge clk); #1; host_write(0, 32'h50, 4'd1, 1'b0); end
    join
    chk("burst_ncmd", 32'(cmd_log.size()), 32'd2);
    if (cmd_log.size() == 2) begin
      chk("burst_order0", 32'(cmd_log[0]), 32'h20);
      chk("burst_order1", 32'(cmd_log[1]), 32'h50);
    end

    // write burst of 8 with waitrequest and host gaps; a1 read on beat 3
    gaps = 1'b1;
    cmd_log.delete();
    fork
      host_write(0, 32'h40, 4'd8, 1'b1);
      begin
        for (int t = 0; t < 2000 && wbeats[0] < 3; t++) @(posedge clk);
        #1;
        host_read(1, 32'h40, 4'd8, tmp1);
      end
    join
    chk("wburst_ncmd", 32'(cmd_log.size()), 32'd2);
    gaps = 1'b0;
    repeat (4) @(posedge clk); #1;

    // reset after 2 of 4 read beats
    a_addr[1] = 32'h60; a_bc[1] = 4'd4; a_rd[1] = 1'b1; exp_rd[1] = 1'b1;
    wait_accept(1, ok);
    a_rd[1] = 1'b0;
    chk("rstb_accept", {31'd0, ok}, 32'd1);
    got = 0;
    for (int t = 0; t < 50 && got < 2; t++) begin
      @(negedge clk);
      if (a_rdv[1]) got++;
    end
    chk("rstb_two_beats", 32'(got), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1; exp_rd[1] = 1'b0;
    @(negedge clk);
    chk("rstb_wait", {30'd0, a_wait}, 32'd3);
    chk("rstb_rdv", {30'd0, a_rdv}, 32'd0);
    chk("rstb_hcmd", {30'd0, h_rd, h_wr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rstb_dropped", {30'd0, a_rdv}, 32'd0);
    end
    @(posedge clk); #1;
    host_read(0, 32'h10, 4'd1, tmp0);
    chk("rstb_next_grant", tmp0, exp_mem[4]);

    // randomized traffic on disjoint halves of the RAM
    gaps = 1'b1;
    fork
      rand_host(0, 30);
      rand_host(1, 30);
    join
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
